// File: rtl/sketch_ctrl_pkg.sv
// Shared types for the sketch bucket read-modify-write controller.
//   ctrl_state_e : clear-sweep / arbitration FSM states
//   op_kind_e    : kind of operation travelling down the RMW pipe
//   pipe_ctl_t   : per-stage control record (valid + op kind)
// The data fields of each stage (address, delta, sum) are kept beside the record in the top,
// because their widths are parameters of the controller instance.
package sketch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StSweep,
    StDone
  } ctrl_state_e;

  typedef enum logic {
    OpUpd,
    OpQry
  } op_kind_e;

  typedef struct packed {
    logic     valid;
    op_kind_e kind;
  } pipe_ctl_t;

  localparam pipe_ctl_t PipeEmpty = '{valid: 1'b0, kind: OpUpd};

endpackage

// File: rtl/sketch_rmw_fwd_unit.sv
// Forward-select mux and adder for the A stage of the bucket RMW pipe.
// Ports:
//   ram_douta : counter value read from the RAM for the A-stage address
//   w_hit     : W stage holds a write to the A-stage address (highest priority)
//   w_sum     : value being written by the W stage
//   wb_hit    : a write to the A-stage address retired in the previous cycle
//   wb_sum    : value of that retired write
//   delta     : zero-extended increment (0 for queries)
//   sum       : updated counter value
// Build option: RMW_SATURATE_EN defined -> sum clamps to all-ones on carry-out,
// otherwise it wraps modulo 2**DW.
module sketch_rmw_fwd_unit #(
  parameter int unsigned DW = 64
) (
  input  logic [DW-1:0] ram_douta,
  input  logic          w_hit,
  input  logic [DW-1:0] w_sum,
  input  logic          wb_hit,
  input  logic [DW-1:0] wb_sum,
  input  logic [DW-1:0] delta,
  output logic [DW-1:0] sum
);

  logic [DW-1:0] base;

  // The RAM read lags two writes behind: the op one ahead is in W, the op two ahead wrote in
  // the same cycle our read was issued (read-before-write), so both must be bypassed.
  always_comb begin
    base = ram_douta;
    if (w_hit) begin
      base = w_sum;
    end else if (wb_hit) begin
      base = wb_sum;
    end
  end

`ifdef RMW_SATURATE_EN
  logic [DW:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, base} + {1'b0, delta};
    sum      = wide_sum[DW] ? {DW{1'b1}} : wide_sum[DW-1:0];
  end
`else
  always_comb begin
    sum = base + delta;
  end
`endif

endmodule

// File: rtl/sketch_bucket_rmw_ctrl.sv
// Read-modify-write sequencer for one sketch counter bank in a dual-port RAM
// (port A read with 1-cycle registered latency, port B write, read-before-write on collision).
// Arbitrates counter updates against host queries and provides a full-bank clear sweep.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   upd_valid/upd_ready/upd_addr/
//   upd_delta                         : counter update request (add delta to bucket)
//   qry_valid/qry_ready/qry_addr      : bucket query request
//   rsp_valid/rsp_data                : query result, 1-cycle pulse, two cycles after accept
//   clr_start/clr_busy/clr_done       : bank clear control (start sampled only when idle)
//   ram_addra/ram_douta               : RAM read port
//   ram_web/ram_addrb/ram_dinb        : RAM write port
// Pipe: R (issue read) -> A (forward + add, registered) -> W (write back or respond).
// Build option: RMW_SATURATE_EN (saturating counters, see sketch_rmw_fwd_unit).
module sketch_bucket_rmw_ctrl
  import sketch_ctrl_pkg::*;
#(
  parameter int unsigned DPW = 10,
  parameter int unsigned DW  = 64,
  parameter int unsigned DLW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           upd_valid,
  output logic           upd_ready,
  input  logic [DPW-1:0] upd_addr,
  input  logic [DLW-1:0] upd_delta,
  input  logic           qry_valid,
  output logic           qry_ready,
  input  logic [DPW-1:0] qry_addr,
  output logic           rsp_valid,
  output logic [DW-1:0]  rsp_data,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic           clr_done,
  output logic [DPW-1:0] ram_addra,
  input  logic [DW-1:0]  ram_douta,
  output logic           ram_web,
  output logic [DPW-1:0] ram_addrb,
  output logic [DW-1:0]  ram_dinb
);

  ctrl_state_e state_q, state_d;

  logic           rr_q;  // 1: query wins the next contested cycle
  logic           upd_grant, qry_grant, accept, arb_open;
  logic [DPW-1:0] acc_addr, addra_q;

  pipe_ctl_t      a_ctl_q, w_ctl_q;
  logic [DPW-1:0] a_addr_q, w_addr_q, wb_addr_q;
  logic [DLW-1:0] a_delta_q;
  logic [DW-1:0]  w_sum_q, wb_sum_q, fwd_sum;
  logic           wb_valid_q;
  logic           w_hit, wb_hit, w_is_write;

  logic [DPW:0]   sweep_q;
  logic           sweep_last, sweep_we;

  // ---------------------------------------------------------------- arbitration / R stage
  // A clr_start seen in idle closes the arbiter for that cycle so the clear wins.
  assign arb_open  = (state_q == StIdle) && !clr_start;
  assign upd_grant = arb_open && upd_valid && (!qry_valid || !rr_q);
  assign qry_grant = arb_open && qry_valid && (!upd_valid || rr_q);
  assign accept    = upd_grant || qry_grant;
  assign upd_ready = upd_grant;
  assign qry_ready = qry_grant;
  assign acc_addr  = upd_grant ? upd_addr : qry_addr;

  // Read address only moves for accepted ops; idle cycles re-read the last address.
  assign ram_addra = accept ? acc_addr : addra_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      addra_q <= '0;
    end else begin
      addra_q <= ram_addra;
      if (upd_valid && qry_valid && accept) begin
        rr_q <= ~rr_q;
      end
    end
  end

  // ---------------------------------------------------------------- A / W / W+1 stages
  assign w_is_write = w_ctl_q.valid && (w_ctl_q.kind == OpUpd);
  assign w_hit      = w_is_write && (w_addr_q == a_addr_q);
  assign wb_hit     = wb_valid_q && (wb_addr_q == a_addr_q);

  sketch_rmw_fwd_unit #(
    .DW (DW)
  ) u_fwd (
    .ram_douta (ram_douta),
    .w_hit     (w_hit),
    .w_sum     (w_sum_q),
    .wb_hit    (wb_hit),
    .wb_sum    (wb_sum_q),
    .delta     (DW'(a_delta_q)),
    .sum       (fwd_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ctl_q    <= PipeEmpty;
      a_addr_q   <= '0;
      a_delta_q  <= '0;
      w_ctl_q    <= PipeEmpty;
      w_addr_q   <= '0;
      w_sum_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_sum_q   <= '0;
    end else begin
      a_ctl_q <= '{valid: accept, kind: (qry_grant ? OpQry : OpUpd)};
      if (accept) begin
        a_addr_q  <= acc_addr;
        a_delta_q <= upd_grant ? upd_delta : '0;
      end
      w_ctl_q <= a_ctl_q;
      if (a_ctl_q.valid) begin
        w_addr_q <= a_addr_q;
        w_sum_q  <= fwd_sum;
      end
      wb_valid_q <= w_is_write;
      if (w_is_write) begin
        wb_addr_q <= w_addr_q;
        wb_sum_q  <= w_sum_q;
      end
    end
  end

  // ---------------------------------------------------------------- clear FSM
  assign sweep_last = (sweep_q == {1'b0, {DPW{1'b1}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDrain) begin
        sweep_q <= '0;
      end else if (state_q == StSweep) begin
        sweep_q <= sweep_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (clr_start) state_d = StDrain;
      StDrain: if (!a_ctl_q.valid && !w_ctl_q.valid) state_d = StSweep;
      StSweep: if (sweep_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_busy = (state_q != StIdle);
    clr_done = (state_q == StDone);
    sweep_we = (state_q == StSweep);
  end

  // ---------------------------------------------------------------- RAM write port / response
  assign ram_web   = sweep_we || w_is_write;
  assign ram_addrb = sweep_we ? sweep_q[DPW-1:0] : w_addr_q;
  assign ram_dinb  = sweep_we ? '0 : w_sum_q;
  assign rsp_valid = w_ctl_q.valid && (w_ctl_q.kind == OpQry);
  assign rsp_data  = w_sum_q;

endmodule

// File: tb/tb_sketch_bucket_rmw_ctrl.sv
// Self-checking bench for sketch_bucket_rmw_ctrl: a bench-side dual-port RAM, a bank-level
// reference model (array of counters updated in accept order) and directed/random scenarios.
module tb_sketch_bucket_rmw_ctrl;

  localparam int DPW   = 10;
  localparam int DW    = 64;
  localparam int DLW   = 16;
  localparam int Depth = 1 << DPW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           upd_valid = 1'b0, upd_ready;
  logic [DPW-1:0] upd_addr = '0;
  logic [DLW-1:0] upd_delta = '0;
  logic           qry_valid = 1'b0, qry_ready;
  logic [DPW-1:0] qry_addr = '0;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           clr_start = 1'b0, clr_busy, clr_done;
  logic [DPW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0]  ram_douta, ram_dinb;
  logic           ram_web;

  logic           preset_en = 1'b0;
  logic [DPW-1:0] preset_addr = '0;
  logic [DW-1:0]  preset_val = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] last_rsp;

  typedef struct {
    logic [DW-1:0] val;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] mem[Depth] = '{default: '0};
  logic [DW-1:0] ref_mem[Depth] = '{default: '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench RAM: registered read, read-before-write on collision, contents survive reset.
  always @(posedge clk) begin
    ram_douta <= mem[ram_addra];
    if (ram_web) mem[ram_addrb] <= ram_dinb;
    if (preset_en) mem[preset_addr] <= preset_val;
  end

  sketch_bucket_rmw_ctrl #(
    .DPW (DPW),
    .DW  (DW),
    .DLW (DLW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_addr  (upd_addr),
    .upd_delta (upd_delta),
    .qry_valid (qry_valid),
    .qry_ready (qry_ready),
    .qry_addr  (qry_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_addra (ram_addra),
    .ram_douta (ram_douta),
    .ram_web   (ram_web),
    .ram_addrb (ram_addrb),
    .ram_dinb  (ram_dinb)
  );

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] d);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, d};
`ifdef RMW_SATURATE_EN
    if (s[DW]) return {DW{1'b1}};
`endif
    return s[DW-1:0];
  endfunction

  // Scoreboard: every accepted query must answer two cycles later with the bank value as of
  // its accept, i.e. after all earlier-accepted updates.
  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        continue;
      end
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected cyc=%0d data=%0h", cyc, rsp_data);
        end else begin
          e = exp_q.pop_front();
          last_rsp = rsp_data;
          if (rsp_data !== e.val || cyc != e.cyc + 2) begin
            failures++;
            $display("FAIL rsp_data cyc=%0d got=%0h want=%0h accept_cyc=%0d", cyc, rsp_data,
                     e.val, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2) begin
        checks++;
        failures++;
        $display("FAIL rsp_missing cyc=%0d want=%0h", cyc, exp_q[0].val);
        void'(exp_q.pop_front());
      end
      if (upd_valid && qry_valid) begin
        checks++;
        if (upd_ready && qry_ready) begin
          failures++;
          $display("FAIL double_grant cyc=%0d got=both want=one", cyc);
        end
      end
      if (upd_valid && upd_ready)
        ref_mem[upd_addr] = model_add(ref_mem[upd_addr], DW'(upd_delta));
      if (qry_valid && qry_ready) begin
        e.val = ref_mem[qry_addr];
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (clr_start && !clr_busy)
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
      if (preset_en) ref_mem[preset_addr] = preset_val;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic send_upd(input logic [DPW-1:0] a, input logic [DLW-1:0] d);
    int n;
    n = 0;
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_delta = d;
    @(negedge clk);
    while (!upd_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ready) begin
      checks++;
      failures++;
      $display("FAIL upd_accept_timeout got=not_ready want=ready addr=%0d", a);
    end
    step();
    upd_valid = 1'b0;
  endtask

  task automatic send_qry(input logic [DPW-1:0] a);
    int n;
    n = 0;
    qry_valid = 1'b1;
    qry_addr  = a;
    @(negedge clk);
    while (!qry_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!qry_ready) begin
      checks++;
      failures++;
      $display("FAIL qry_accept_timeout got=not_ready want=ready addr=%0d", a);
    end
    step();
    qry_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({upd_ready, qry_ready, rsp_valid, clr_busy, clr_done, ram_web} !== 6'b0) begin
      failures++;
      $display("FAIL %s_ctrl got=%b want=000000", tag,
               {upd_ready, qry_ready, rsp_valid, clr_busy, clr_done, ram_web});
    end
    checks++;
    if (ram_addra !== '0 || ram_addrb !== '0) begin
      failures++;
      $display("FAIL %s_addr got=%0h/%0h want=0/0", tag, ram_addra, ram_addrb);
    end
    checks++;
    if (ram_dinb !== '0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL %s_data got=%0h/%0h want=0/0", tag, ram_dinb, rsp_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    send_upd(10'd5, 16'd3);
    send_qry(10'd5);
    drain();
    checks++;
    if (last_rsp !== 64'd3) begin
      failures++;
      $display("FAIL single got=%0d want=3", last_rsp);
    end
  endtask

  task automatic test_back_to_back();
    send_upd(10'd7, 16'd1);
    send_upd(10'd7, 16'd2);
    send_upd(10'd7, 16'd4);
    send_qry(10'd7);
    drain();
    checks++;
    if (last_rsp !== 64'd7) begin
      failures++;
      $display("FAIL back_to_back got=%0d want=7", last_rsp);
    end
  endtask

  task automatic test_collision();
    send_upd(10'd9, 16'd10);
    step();
    send_upd(10'd9, 16'd10);
    send_qry(10'd9);
    drain();
    checks++;
    if (last_rsp !== 64'd20) begin
      failures++;
      $display("FAIL collision got=%0d want=20", last_rsp);
    end
  endtask

  task automatic test_arbitration();
    int n_upd, n_qry;
    n_upd = 0;
    n_qry = 0;
    upd_valid = 1'b1;
    qry_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      upd_addr  = DPW'($urandom_range(16, 31));
      upd_delta = DLW'($urandom);
      qry_addr  = DPW'($urandom_range(16, 31));
      @(negedge clk);
      if (upd_ready) n_upd++;
      if (qry_ready) n_qry++;
      checks++;
      if (upd_ready !== (i % 2 == 0) || qry_ready !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL arb_grant slot=%0d got=upd%b/qry%b want=upd%b/qry%b", i, upd_ready,
                 qry_ready, (i % 2 == 0), (i % 2 == 1));
      end
      step();
    end
    upd_valid = 1'b0;
    qry_valid = 1'b0;
    checks++;
    if (n_upd != 4 || n_qry != 4) begin
      failures++;
      $display("FAIL arb_count got=%0d/%0d want=4/4", n_upd, n_qry);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      upd_valid = 1'($urandom_range(0, 1));
      qry_valid = 1'($urandom_range(0, 1));
      upd_addr  = DPW'($urandom_range(0, 15));
      qry_addr  = DPW'($urandom_range(0, 15));
      upd_delta = DLW'($urandom);
      step();
    end
    upd_valid = 1'b0;
    qry_valid = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_saturate();
    logic [DW-1:0] want;
`ifdef RMW_SATURATE_EN
    want = {DW{1'b1}};
`else
    want = 64'd3;
`endif
    preset_en   = 1'b1;
    preset_addr = 10'd3;
    preset_val  = {DW{1'b1}} - 1;
    step();
    preset_en = 1'b0;
    send_upd(10'd3, 16'd5);
    send_qry(10'd3);
    drain();
    checks++;
    if (last_rsp !== want) begin
      failures++;
      $display("FAIL saturate got=%0h want=%0h", last_rsp, want);
    end
  endtask

  task automatic test_clear();
    int writes, addr_err, done_cnt, done_cyc, last_wr_cyc, busy_gap, stray;
    writes = 0; addr_err = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -9; busy_gap = 0;
    stray = 0;
    send_upd(10'd0, 16'd5);
    send_upd(10'd1023, 16'd5);
    clr_start = 1'b1;
    upd_valid = 1'b1;
    upd_addr  = 10'd2;
    upd_delta = 16'd1;
    @(negedge clk);
    checks++;
    if (upd_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_wins got=%b want=0", upd_ready);
    end
    step();
    clr_start = 1'b0;
    upd_valid = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done_cnt == 0 && !clr_busy) busy_gap++;
      if (ram_web && clr_busy && ram_dinb == '0) begin
        if (int'(ram_addrb) != writes) addr_err++;
        writes++;
        last_wr_cyc = cyc;
      end
      if (clr_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (writes == 500) clr_start = 1'b1;
      if (writes == 501) clr_start = 1'b0;
      if (done_cnt > 0 && !clr_busy) break;
    end
    clr_start = 1'b0;
    checks++;
    if (writes != Depth || addr_err != 0) begin
      failures++;
      $display("FAIL sweep_writes got=%0d(addr_err=%0d) want=%0d(0)", writes, addr_err, Depth);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL clr_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (busy_gap != 0) begin
      failures++;
      $display("FAIL clr_busy_gap got=%0d want=0", busy_gap);
    end
    repeat (20) begin
      @(negedge clk);
      if (clr_busy || clr_done || ram_web) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL clr_restart got=%0d want=0", stray);
    end
    step();
    send_qry(10'd0);
    send_qry(10'd1023);
    drain();
    checks++;
    if (last_rsp !== '0) begin
      failures++;
      $display("FAIL cleared_value got=%0h want=0", last_rsp);
    end
  endtask

  task automatic test_reset_during_sweep();
    int seen;
    seen = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (100) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("sweep_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (1200) begin
      @(negedge clk);
      if (clr_done || clr_busy || ram_web) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL sweep_abort got=%0d want=0", seen);
    end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_arbitration();
    test_random();
    test_saturate();
    test_clear();
    test_reset_during_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
